sqrt_iter_core: RTL

- Iterative radix-2 restoring integer square-root engine for the floating-point ALU square-root path.
- Each cycle it forms one root bit. It does this with a row of borrow-propagate subtract/restore cells (the bo/d cell function), applied to the partial remainder and the trial divisor.
- Sits between the FP sqrt operand unpacker (which supplies the exponent-adjusted mantissa) and the normaliser/rounder (which consumes the root and the sticky remainder).
- Uses a valid/ready handshake on both sides.

---
 rtl/sqrt_iter_core.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sqrt_iter_core.sv
// Radix-2 restoring integer square root: one root bit per clock through a borrow-propagate subtract/restore row.
// Latency: WIDTH/2 edges from the accepting edge to out_valid, independent of the operand.
// Backpressure: result held in DONE until out_ready; in_ready is low from acceptance until the cycle after the result is taken.
module sqrt_iter_core #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     radicand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH/2-1:0]   root,
    output logic [WIDTH/2:0]     remainder,
    output logic                 busy
);

    localparam int RW   = WIDTH / 2;
    localparam int REMW = RW + 1;
    localparam int AW   = RW + 3;
    localparam int CNTW = $clog2(RW + 1);

    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(RW);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] xReg;
    logic [RW-1:0]   qReg;
    logic [REMW-1:0] rReg;
    logic [CNTW-1:0] cnt;

    logic [AW-1:0]   aVec;
    logic [AW-1:0]   sVec;
    logic [REMW-1:0] diff;
    logic            borrow;
    logic [REMW-1:0] rNext;
    logic [RW-1:0]   qNext;

    // Row of bo/d cells. The upper positions only propagate borrow: the
    // kept remainder never exceeds REMW bits, so their difference bits are
    // always zero whenever the trial result is accepted.
    function automatic logic [REMW:0] trialSub(input logic [AW-1:0] a, input logic [AW-1:0] s);
        logic            b;
        logic [REMW-1:0] d;
        b = 1'b0;
        d = '0;
        for (int i = 0; i < REMW; i++) begin
            d[i] = a[i] ^ s[i] ^ b;
            b    = (~a[i] & s[i]) | (~(a[i] ^ s[i]) & b);
        end
        for (int i = REMW; i < AW; i++) begin
            b = (~a[i] & s[i]) | (~(a[i] ^ s[i]) & b);
        end
        return {b, d};
    endfunction

    always_comb begin
        aVec           = {rReg, xReg[WIDTH-1 -: 2]};
        sVec           = {1'b0, qReg, 2'b01};
        {borrow, diff} = trialSub(aVec, sVec);
        rNext          = borrow ? aVec[REMW-1:0] : diff;
        qNext          = {qReg[RW-2:0], ~borrow};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            root      <= '0;
            remainder <= '0;
            xReg      <= '0;
            qReg      <= '0;
            rReg      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        xReg     <= radicand;
                        qReg     <= '0;
                        rReg     <= '0;
                        cnt      <= CNT_LOAD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    xReg <= xReg << 2;
                    qReg <= qNext;
                    rReg <= rNext;
                    cnt  <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        root      <= qNext;
                        remainder <= rNext;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
